// File: rtl/vga_bus_arbiter_pkg.sv
// Shared definitions for the VGA bus arbiter: strobe/ack bit positions common
// with the motherboard sequencer and the transaction state encoding.
package vga_bus_arbiter_pkg;

  localparam int VGA_WRITE_PIN = 0;
  localparam int VGA_READ_PIN  = 1;
  localparam int VGA_ACK       = 0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_IDLE = 2'd1,
    ACTIVE    = 2'd2,
    DONE      = 2'd3
  } arb_state_e;

  // Strobe bit that carries a transaction of the given direction.
  function automatic int strobe_pin(input logic we);
    return we ? VGA_WRITE_PIN : VGA_READ_PIN;
  endfunction

endpackage

// File: rtl/vga_bus_arbiter_if.sv
// Requester and VGA device signals of the arbiter. The master modport is the
// arbiter's view; the slave modport is the requesters and the VGA controller.
interface vga_bus_arbiter_if #(
  parameter int word_width = 32
);

  logic                  r0_req;
  logic                  r1_req;
  logic                  r0_we;
  logic                  r1_we;
  logic [word_width-1:0] r0_addr;
  logic [word_width-1:0] r1_addr;
  logic [word_width-1:0] r0_wdata;
  logic [word_width-1:0] r1_wdata;
  logic [word_width-1:0] r0_rdata;
  logic [word_width-1:0] r1_rdata;
  logic                  r0_done;
  logic                  r1_done;
  logic [word_width-1:0] vga_ctrl;
  logic [word_width-1:0] vga_stat;
  logic [word_width-1:0] addr;
  logic [word_width-1:0] data_out;
  logic [word_width-1:0] data_in;
  logic                  err;

  modport master (
    input  r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata,
    input  vga_stat, data_in,
    output r0_rdata, r1_rdata, r0_done, r1_done,
    output vga_ctrl, addr, data_out, err
  );

  modport slave (
    output r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata,
    output vga_stat, data_in,
    input  r0_rdata, r1_rdata, r0_done, r1_done,
    input  vga_ctrl, addr, data_out, err
  );

endinterface

// File: rtl/vga_bus_arbiter_rr_arb2.sv
// Two-input round-robin grant with a last-served pointer. After reset the
// pointer names port 1 as last served, so port 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic       grant,
  output logic       any_req
);

  logic last_r;

  // Grant selection: a sole requester wins, a tie goes to the port not served last.
  always_comb begin
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_r;
      default: grant = 1'b0;
    endcase
  end

  assign any_req = |req;

  // Last-served pointer, moved only when a transaction completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (update) begin
      last_r <= served;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/vga_bus_arbiter.sv
// VGA bus sequencer and two-port round-robin arbiter. Optional ACK watchdog
// is enabled by defining VGA_ARB_TIMEOUT_EN.
module vga_bus_arbiter
  import vga_bus_arbiter_pkg::*;
#(
  parameter int word_width     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  vga_bus_arbiter_if.master bus
);

  localparam logic [word_width-1:0] ALL_ONES = {word_width{1'b1}};

  arb_state_e            state_r;
  logic                  win_r;
  logic                  we_r;
  logic                  grant_s;
  logic                  any_req_s;
  logic                  ack_s;
  logic                  timeout_s;
  logic                  complete_s;
  logic                  sel_we_s;
  logic [word_width-1:0] sel_addr_s;
  logic [word_width-1:0] sel_wdata_s;
  logic [word_width-1:0] ret_data_s;
  logic                  unused_stat_s;

  assign ack_s         = bus.vga_stat[VGA_ACK];
  assign unused_stat_s = ^bus.vga_stat;

  function automatic logic [word_width-1:0] strobe_word(input logic we);
    logic [word_width-1:0] w;
    w = {word_width{1'b0}};
    w[strobe_pin(we)] = 1'b1;
    return w;
  endfunction

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .req     ({bus.r1_req, bus.r0_req}),
    .update  (complete_s),
    .served  (win_r),
    .grant   (grant_s),
    .any_req (any_req_s)
  );

  // Winner's transaction fields as seen in IDLE.
  always_comb begin
    sel_we_s    = bus.r0_we;
    sel_addr_s  = bus.r0_addr;
    sel_wdata_s = bus.r0_wdata;
    if (grant_s) begin
      sel_we_s    = bus.r1_we;
      sel_addr_s  = bus.r1_addr;
      sel_wdata_s = bus.r1_wdata;
    end else begin
      sel_we_s    = bus.r0_we;
      sel_addr_s  = bus.r0_addr;
      sel_wdata_s = bus.r0_wdata;
    end
  end

`ifdef VGA_ARB_TIMEOUT_EN
  localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;
  logic             err_r;

  assign timeout_s = (state_r == ACTIVE) && !ack_s && (cnt_r == CNT_LIMIT);
  assign bus.err   = err_r;
`else
  logic unused_cfg_s;

  assign timeout_s    = 1'b0;
  assign unused_cfg_s = (TIMEOUT_CYCLES > 0);
  assign bus.err      = 1'b0;
`endif

  // Completion happens on ACK in ACTIVE, or on watchdog expiry with all-ones data.
  always_comb begin
    complete_s = 1'b0;
    ret_data_s = bus.data_in;
    if (state_r == ACTIVE) begin
      complete_s = ack_s || timeout_s;
      ret_data_s = ack_s ? bus.data_in : ALL_ONES;
    end else begin
      complete_s = 1'b0;
      ret_data_s = bus.data_in;
    end
  end

  // Transaction sequencer; every bus and requester output is a register here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      win_r        <= 1'b0;
      we_r         <= 1'b0;
      bus.addr     <= {word_width{1'b0}};
      bus.data_out <= {word_width{1'b0}};
      bus.vga_ctrl <= {word_width{1'b0}};
      bus.r0_rdata <= {word_width{1'b0}};
      bus.r1_rdata <= {word_width{1'b0}};
      bus.r0_done  <= 1'b0;
      bus.r1_done  <= 1'b0;
`ifdef VGA_ARB_TIMEOUT_EN
      cnt_r        <= {CNT_W{1'b0}};
      err_r        <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            win_r    <= grant_s;
            we_r     <= sel_we_s;
            bus.addr <= sel_addr_s;
            if (sel_we_s) begin
              bus.data_out <= sel_wdata_s;
            end
            state_r <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          // The device must drop ACK from its previous cycle before a new strobe.
          if (!ack_s) begin
            bus.vga_ctrl <= strobe_word(we_r);
            state_r      <= ACTIVE;
`ifdef VGA_ARB_TIMEOUT_EN
            cnt_r        <= {CNT_W{1'b0}};
`endif
          end
        end
        ACTIVE: begin
          if (complete_s) begin
            bus.vga_ctrl <= {word_width{1'b0}};
            if (!we_r) begin
              if (win_r) begin
                bus.r1_rdata <= ret_data_s;
              end else begin
                bus.r0_rdata <= ret_data_s;
              end
            end
            if (win_r) begin
              bus.r1_done <= 1'b1;
            end else begin
              bus.r0_done <= 1'b1;
            end
`ifdef VGA_ARB_TIMEOUT_EN
            err_r <= err_r | timeout_s;
`endif
            state_r <= DONE;
          end else begin
`ifdef VGA_ARB_TIMEOUT_EN
            cnt_r <= cnt_r + CNT_ONE;
`endif
            state_r <= ACTIVE;
          end
        end
        DONE: begin
          bus.r0_done <= 1'b0;
          bus.r1_done <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_bus_arbiter.sv
// Randomized bench for vga_bus_arbiter: a transaction-level requester/device
// model predicts grant order, strobes, read data and done pulses.
module tb_vga_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_bus_arbiter_if #(.word_width(32)) bus ();

  vga_bus_arbiter #(.word_width(32), .TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: outstanding transactions per port and the last port served.
  int          remaining [2];
  logic        last_served;
  logic        tr_we    [2];
  logic [31:0] tr_addr  [2];
  logic [31:0] tr_wdata [2];
  logic [31:0] m_rdata  [2];

  // Device model state.
  logic        dev_ack;
  logic [31:0] dev_data;
  int          dev_cnt, dev_tail, dev_lat_max, dev_tail_max;
  bit          dev_noack, dev_force;
  logic [31:0] dev_force_val, rd_val, prev_ctrl;
  bit          strobe_seen;
  int          strobe_cycles, cyc, first_done_cyc, done_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic next_port();
    if (remaining[0] > 0 && remaining[1] > 0) return ~last_served;
    else if (remaining[1] > 0) return 1'b1;
    else return 1'b0;
  endfunction

  task automatic drive_inputs();
    bus.r0_req   = (remaining[0] > 0);
    bus.r1_req   = (remaining[1] > 0);
    bus.r0_we    = tr_we[0];
    bus.r1_we    = tr_we[1];
    bus.r0_addr  = tr_addr[0];
    bus.r1_addr  = tr_addr[1];
    bus.r0_wdata = tr_wdata[0];
    bus.r1_wdata = tr_wdata[1];
    bus.vga_stat = {31'd0, dev_ack};
    bus.data_in  = dev_data;
  endtask

  task automatic new_tr(input int p);
    tr_we[p]    = 1'($urandom_range(1, 0));
    tr_addr[p]  = $urandom;
    tr_wdata[p] = $urandom;
  endtask

  task automatic model_reset();
    remaining[0] = 0; remaining[1] = 0;
    last_served  = 1'b1;
    m_rdata[0]   = 32'd0; m_rdata[1] = 32'd0;
    dev_ack = 1'b0; dev_noack = 1'b0; dev_force = 1'b0;
    prev_ctrl = 32'd0; strobe_seen = 1'b0;
  endtask

  // One clock: observe DUT at the falling edge, then advance the device and requesters.
  task automatic step();
    logic ep;
    int   p;
    @(negedge clk);
    cyc++;
    ep = next_port();
    if (bus.vga_ctrl != 32'd0 && prev_ctrl == 32'd0) begin
      check_eq("strobe_after_ack_low", {31'd0, dev_ack}, 32'd0);
      check_eq("strobe_kind", bus.vga_ctrl, tr_we[ep] ? 32'd1 : 32'd2);
      check_eq("strobe_addr", bus.addr, tr_addr[ep]);
      if (tr_we[ep]) check_eq("strobe_wdata", bus.data_out, tr_wdata[ep]);
      strobe_seen = 1'b1;
      dev_cnt = $urandom_range(dev_lat_max, 0);
    end else if (bus.vga_ctrl != 32'd0 && bus.vga_ctrl != prev_ctrl) begin
      check_eq("ctrl_stable", bus.vga_ctrl, prev_ctrl);
    end
    if (bus.vga_ctrl != 32'd0) strobe_cycles++;
    if (bus.r0_done || bus.r1_done) begin
      p = bus.r1_done ? 1 : 0;
      check_eq("done_onehot", {31'd0, bus.r0_done & bus.r1_done}, 32'd0);
      check_eq("grant", p, {31'd0, ep});
      check_eq("ctrl_clear_at_done", bus.vga_ctrl, 32'd0);
      check_eq("strobe_seen", {31'd0, strobe_seen}, 32'd1);
      if (!tr_we[p]) m_rdata[p] = rd_val;
      check_eq(p ? "r1_rdata" : "r0_rdata", p ? bus.r1_rdata : bus.r0_rdata, m_rdata[p]);
      check_eq(p ? "r0_rdata_hold" : "r1_rdata_hold", p ? bus.r0_rdata : bus.r1_rdata, m_rdata[1-p]);
      if (done_cnt == 0) first_done_cyc = cyc;
      done_cnt++;
      last_served = p[0];
      remaining[p]--;
      if (remaining[p] > 0) new_tr(p);
      strobe_seen = 1'b0;
    end
    if (bus.vga_ctrl != 32'd0) begin
      if (!dev_ack && !dev_noack) begin
        if (dev_cnt == 0) begin
          dev_ack  = 1'b1;
          dev_data = dev_force ? dev_force_val : $urandom;
          rd_val   = dev_data;
          dev_tail = $urandom_range(dev_tail_max, 0);
        end else begin
          dev_cnt--;
        end
      end
    end else if (dev_ack) begin
      if (dev_tail == 0) begin
        dev_ack  = 1'b0;
        dev_data = $urandom;
      end else begin
        dev_tail--;
      end
    end
    prev_ctrl = bus.vga_ctrl;
    drive_inputs();
  endtask

  task automatic start_batch(input int n0, input int n1);
    remaining[0] = n0; remaining[1] = n1;
    if (n0 > 0) new_tr(0);
    if (n1 > 0) new_tr(1);
    done_cnt = 0;
    drive_inputs();
  endtask

  task automatic finish_batch(input int budget);
    int t;
    t = 0;
    while ((remaining[0] > 0 || remaining[1] > 0) && t < budget) begin
      step();
      t++;
    end
    if (remaining[0] > 0 || remaining[1] > 0) check_eq("batch_timeout", 32'd1, 32'd0);
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctrl"}, bus.vga_ctrl, 32'd0);
    check_eq({tag, "_addr"}, bus.addr, 32'd0);
    check_eq({tag, "_data_out"}, bus.data_out, 32'd0);
    check_eq({tag, "_done"}, {30'd0, bus.r1_done, bus.r0_done}, 32'd0);
    check_eq({tag, "_rdata"}, bus.r0_rdata | bus.r1_rdata, 32'd0);
  endtask

  initial begin
    int t;
    cyc = 0;
    model_reset();
    tr_we[0] = 1'b0; tr_we[1] = 1'b0;
    tr_addr[0] = 32'd0; tr_addr[1] = 32'd0;
    tr_wdata[0] = 32'd0; tr_wdata[1] = 32'd0;
    dev_data = 32'd0; dev_lat_max = 0; dev_tail_max = 0;
    drive_inputs();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    check_eq("reset_err", {31'd0, bus.err}, 32'd0);
    rst = 1'b0;

    // Single write at minimum latency.
    start_batch(1, 0);
    tr_we[0] = 1'b1; tr_addr[0] = 32'h100; tr_wdata[0] = 32'hDEADBEEF;
    drive_inputs();
    t = cyc; strobe_cycles = 0;
    finish_batch(50);
    check_eq("write_latency", first_done_cyc - t, 32'd3);
    check_eq("write_strobe_cycles", strobe_cycles, 32'd1);
    check_eq("write_addr", bus.addr, 32'h100);

    // Single read with fixed device data.
    dev_force = 1'b1; dev_force_val = 32'h12345678;
    start_batch(0, 1);
    tr_we[1] = 1'b0; tr_addr[1] = 32'h40;
    drive_inputs();
    finish_batch(50);
    check_eq("read_r1_rdata", bus.r1_rdata, 32'h12345678);
    dev_force = 1'b0;

    // Contention with both requests held; ACK lingers to stall WAIT_IDLE.
    dev_lat_max = 2; dev_tail_max = 5;
    start_batch(4, 4);
    finish_batch(400);
    check_eq("contention_count", done_cnt, 32'd8);

    // Randomized batches.
    dev_lat_max = 3;
    for (int b = 0; b < 30; b++) begin
      int n0, n1;
      n0 = $urandom_range(3, 0);
      n1 = (n0 == 0) ? $urandom_range(3, 1) : $urandom_range(3, 0);
      start_batch(n0, n1);
      finish_batch(100 * (n0 + n1));
    end
    check_eq("err_idle", {31'd0, bus.err}, 32'd0);

`ifdef VGA_ARB_TIMEOUT_EN
    // ACK never returns: watchdog completes the read with all-ones.
    dev_noack = 1'b1; rd_val = 32'hFFFFFFFF;
    while (dev_ack) step();
    start_batch(1, 0);
    tr_we[0] = 1'b0;
    drive_inputs();
    strobe_cycles = 0;
    finish_batch(60);
    check_eq("timeout_active_cycles", strobe_cycles, 32'd16);
    check_eq("timeout_rdata", bus.r0_rdata, 32'hFFFFFFFF);
    check_eq("timeout_err", {31'd0, bus.err}, 32'd1);
    dev_noack = 1'b0;
    start_batch(1, 1);
    finish_batch(100);
    check_eq("err_sticky", {31'd0, bus.err}, 32'd1);
`endif

    // Reset while a transaction is in ACTIVE with no ACK.
    while (dev_ack) step();
    dev_noack = 1'b1;
    start_batch(0, 1);
    t = 0;
    while (!strobe_seen && t < 20) begin step(); t++; end
    check_eq("abort_reached_active", {31'd0, strobe_seen}, 32'd1);
    step();
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    check_eq("async_reset_err", {31'd0, bus.err}, 32'd0);
    @(negedge clk);
    model_reset();
    drive_inputs();
    rst = 1'b0;
    done_cnt = 0;
    step();
    check_eq("no_done_after_abort", done_cnt, 32'd0);
    start_batch(1, 1);
    finish_batch(100);
    check_eq("post_reset_count", done_cnt, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_bus_arbiter.md
# vga_bus_arbiter

Sequencer and two-way arbiter for the VGA device bus (`vga_ctrl` / `vga_stat` / `addr` / `data_out` / `data_in`). It runs the VGA read/write handshake on behalf of two requesters: port 0, the motherboard CPU path, and port 1, a secondary master such as a blitter or palette loader. Grants are round-robin, one transaction at a time. The block sits between the motherboard sequencer and the VGA controller, and is the only driver of the VGA bus.

## Interface
Parameters:
- `word_width`, 32, width of address, data, ctrl and stat words.
- `TIMEOUT_CYCLES`, 1024, ACK watchdog limit. Used only when `VGA_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `r0_req`, `r1_req`  in  1  transaction request; held high until `rN_done`.
- `r0_we`, `r1_we`  in  1  1 = write, 0 = read; valid while `req` is high.
- `r0_addr`, `r1_addr`  in  word_width  translated VGA address.
- `r0_wdata`, `r1_wdata`  in  word_width  write data.
- `r0_rdata`, `r1_rdata`  out  word_width  read data; valid in the `done` cycle, held until that port's next read.
- `r0_done`, `r1_done`  out  1  one-cycle completion pulse.
- `vga_ctrl`  out  word_width  bit `VGA_WRITE_PIN` / `VGA_READ_PIN` strobes; all other bits 0.
- `vga_stat`  in  word_width  bit `VGA_ACK` is the device acknowledge.
- `addr`  out  word_width  VGA address.
- `data_out`  out  word_width  VGA write data.
- `data_in`  in  word_width  VGA read data.
- `err`  out  1  sticky timeout flag. Tied 0 when the macro is off.

## Operation
- All outputs are registered. On reset: state IDLE, every output 0, round-robin pointer set to favour port 0.
- IDLE:
  - If any `req` is high, pick the winner.
  - Only one request: that port wins.
  - Both requesting: the port not served last wins.
  - Latch the winner's `we` / `addr` / `wdata` into `addr` / `data_out` (`data_out` is left unchanged on reads). Go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay while `vga_stat[VGA_ACK]` = 1. The device must first finish the previous cycle.
  - When ACK = 0: set `vga_ctrl[VGA_WRITE_PIN]` or `vga_ctrl[VGA_READ_PIN]` per `we`. Go to ACTIVE.
- ACTIVE:
  - Hold `vga_ctrl`, `addr`, `data_out` stable.
  - When ACK = 1:
    - clear `vga_ctrl` to 0;
    - on a read, capture `data_in` into the winner's `rdata`;
    - pulse the winner's `done`;
    - update the pointer to the winner;
    - go to DONE.
- DONE: deassert `done`. Go to IDLE.
- A request that drops mid-transaction is ignored. The transaction completes and `done` still pulses.
- A `req` still high in the IDLE cycle after `done` is treated as a new transaction. Requesters must drop `req` on `done` to avoid a repeat.
- Never more than one strobe bit set. `vga_ctrl` is 0 in IDLE, WAIT_IDLE and DONE.

## Timing
- Minimum latency is 3 edges from `req` sampled in IDLE to `done` high. This requires ACK = 0 at WAIT_IDLE and ACK = 1 in the first ACTIVE cycle.
- Back-to-back throughput: 4 cycles per transaction minimum (IDLE, WAIT_IDLE, ACTIVE, DONE).
- The ACK response time is unbounded unless the watchdog is enabled.
- Fairness: with both ports requesting continuously, grants alternate 0, 1, 0, 1, …
- `rst` asserted in any state aborts immediately. All outputs go to 0 asynchronously and no `done` is issued for the aborted transaction.

## Configuration
- `VGA_ARB_TIMEOUT_EN` defined:
  - a counter runs in ACTIVE;
  - if ACK is not seen within `TIMEOUT_CYCLES` cycles, clear `vga_ctrl`, return all-ones read data, pulse `done`, set sticky `err`, go to DONE;
  - `err` is cleared only by reset.
- `VGA_ARB_TIMEOUT_EN` undefined: no counter; ACTIVE waits indefinitely; `err` is constant 0.

## Structure
- Shared package holds:
  - bit indices `VGA_WRITE_PIN` = 0, `VGA_READ_PIN` = 1, `VGA_ACK` = 0 (common with the motherboard sequencer);
  - the state encoding IDLE / WAIT_IDLE / ACTIVE / DONE.
- One sub-module, `rr_arb2`: two-input round-robin grant logic with the last-served pointer. Everything else lives in the top module.

## Test plan
- Single write: port 0, addr 0x100, wdata 0xDEADBEEF; device ACKs one cycle after the strobe → `vga_ctrl` = 0x1 for exactly the ACTIVE cycles, `addr` = 0x100, `r0_done` one pulse 3 edges after `req`.
- Single read: port 1, addr 0x40; device returns 0x12345678 with ACK → `vga_ctrl` = 0x2, `r1_rdata` = 0x12345678 in the `done` cycle.
- Contention: both ports request from reset and hold `req` through four transactions each → grant order 0, 1, 0, 1; no overlapping strobes.
- ACK stuck high entering WAIT_IDLE for 5 cycles → strobe appears only after ACK falls.
- Reset asserted in ACTIVE → `vga_ctrl`, `done`, `addr` go to 0 immediately; state returns to IDLE; next grant goes to port 0.
- With `VGA_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16, ACK never returns → `done` fires after 16 ACTIVE cycles, `rdata` = 0xFFFFFFFF, `err` = 1 until reset.
